// File: rtl/dcache_tl_pkg.sv
`default_nettype none
// ==========================================================================
// dcache_tl_pkg : TileLink D-channel opcodes and beat-count helpers. Rev 1.0
// ==========================================================================
package dcache_tl_pkg;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic logic has_data(input logic [2:0] opcode);
    return (opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA);
  endfunction

  // Only data-carrying messages larger than one beat span several beats.
  function automatic logic [31:0] beats_of(input logic [2:0]  opcode,
                                           input int unsigned size,
                                           input int unsigned beat_bytes);
    int unsigned lg;
    lg = $clog2(beat_bytes);
    if (has_data(opcode) && (size > lg)) begin
      return 32'd1 << (size - lg);
    end
    return 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_rr_pick.sv
`default_nettype none
// ==========================================================================
// dcache_rr_pick : rotate-priority encoder, first valid at or after ptr_i. Rev 1.0
// ==========================================================================
module dcache_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          c;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest valid entry wins last.
  always_comb begin
    idx_o = '0;
    c     = 0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= N) begin
        c = c - N;
      end
      cand = IW'(c);
      if (valid_i[cand]) begin
        idx_o = cand;
      end
    end
  end

  assign any_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/dcache_tl_d_arbiter.sv
`default_nettype none
// ==========================================================================
// dcache_tl_d_arbiter : round-robin TileLink D arbiter, burst-locked grant. Rev 1.0
// ==========================================================================
module dcache_tl_d_arbiter
  import dcache_tl_pkg::*;
#(
  parameter int NUM_IN   = 2,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int SOURCE_W = 2,
  parameter int USER_W   = 4,
  parameter int CNT_W    = 6,
  localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic [NUM_IN*3-1:0]        in_opcode,
  input  logic [NUM_IN*SIZE_W-1:0]   in_size,
  input  logic [NUM_IN*SOURCE_W-1:0] in_source,
  input  logic [NUM_IN-1:0]          in_denied,
  input  logic [NUM_IN-1:0]          in_corrupt,
  input  logic [NUM_IN*USER_W-1:0]   in_user,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_opcode,
  output logic [SIZE_W-1:0]          out_size,
  output logic [SOURCE_W-1:0]        out_source,
  output logic                       out_denied,
  output logic                       out_corrupt,
  output logic [USER_W-1:0]          out_user,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       proto_err
);

  localparam int BEAT_BYTES = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]    lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [2:0]          lock_opcode_q, lock_opcode_d;
  logic [SIZE_W-1:0]   lock_size_q, lock_size_d;
  logic                proto_err_q, proto_err_d;

  logic [SEL_W-1:0]    win_idx;
  logic                win_any;
  logic [SEL_W-1:0]    sel;
  logic [2:0]          cur_opcode;
  logic [SIZE_W-1:0]   cur_size;
  logic [31:0]         beats;
  logic                fire;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  dcache_rr_pick #(
    .N  (NUM_IN),
    .IW (SEL_W)
  ) u_pick (
    .valid_i (in_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign sel        = (state_q == ARB_BURST) ? lock_idx_q : win_idx;
  assign cur_opcode = in_opcode[sel*3 +: 3];
  assign cur_size   = in_size[sel*SIZE_W +: SIZE_W];
  assign beats      = beats_of(cur_opcode, int'(cur_size), BEAT_BYTES);

  assign out_opcode  = cur_opcode;
  assign out_size    = cur_size;
  assign out_source  = in_source[sel*SOURCE_W +: SOURCE_W];
  assign out_denied  = in_denied[sel];
  assign out_corrupt = in_corrupt[sel];
  assign out_user    = in_user[sel*USER_W +: USER_W];
  assign out_data    = in_data[sel*DATA_W +: DATA_W];
  assign out_sel     = sel;
  assign proto_err   = proto_err_q;

  // Handshakes are gated by reset_n so nothing is offered while reset is held.
  assign out_valid = reset_n &&
                     ((state_q == ARB_BURST) ? in_valid[lock_idx_q] : win_any);
  assign fire      = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    if (reset_n && ((state_q == ARB_BURST) || win_any)) begin
      in_ready[sel] = out_ready;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lock_idx_d    = lock_idx_q;
    remaining_d   = remaining_q;
    lock_opcode_d = lock_opcode_q;
    lock_size_d   = lock_size_q;
    proto_err_d   = proto_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (fire) begin
          if (beats == 32'd1) begin
            rr_ptr_d = next_idx(win_idx);
          end else begin
            state_d       = ARB_BURST;
            lock_idx_d    = win_idx;
            remaining_d   = CNT_W'(beats - 32'd1);
            lock_opcode_d = cur_opcode;
            lock_size_d   = cur_size;
          end
        end
      end
      ARB_BURST: begin
        if (fire) begin
          remaining_d = remaining_q - 1'b1;
          // Every beat of a burst must repeat the first beat's header.
          if ((cur_opcode != lock_opcode_q) || (cur_size != lock_size_q)) begin
            proto_err_d = 1'b1;
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_idx(lock_idx_q);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      lock_idx_q    <= '0;
      remaining_q   <= '0;
      lock_opcode_q <= '0;
      lock_size_q   <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_idx_q    <= lock_idx_d;
      remaining_q   <= remaining_d;
      lock_opcode_q <= lock_opcode_d;
      lock_size_q   <= lock_size_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_tl_d_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_dcache_tl_d_arbiter : vector table, directed corner sequences, random traffic. Rev 1.0
// ==========================================================================
module tb_dcache_tl_d_arbiter;

  localparam int N       = 3;
  localparam int DW      = 32;
  localparam int SW      = 3;
  localparam int SRCW    = 2;
  localparam int UW      = 4;
  localparam int CW      = 6;
  localparam int SELW    = 2;
  localparam int BEAT_LG = 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [N-1:0]      in_valid, in_ready, in_denied, in_corrupt;
  logic [N*3-1:0]    in_opcode;
  logic [N*SW-1:0]   in_size;
  logic [N*SRCW-1:0] in_source;
  logic [N*UW-1:0]   in_user;
  logic [N*DW-1:0]   in_data;
  logic              out_valid, out_ready, out_denied, out_corrupt, proto_err;
  logic [2:0]        out_opcode;
  logic [SW-1:0]     out_size;
  logic [SRCW-1:0]   out_source;
  logic [UW-1:0]     out_user;
  logic [DW-1:0]     out_data;
  logic [SELW-1:0]   out_sel;

  bit               t_v[N];
  logic [2:0]       t_op[N];
  logic [SW-1:0]    t_sz[N];
  logic [SRCW-1:0]  t_src[N];
  logic             t_den[N];
  logic             t_cor[N];
  logic [UW-1:0]    t_usr[N];
  logic [DW-1:0]    t_dat[N];
  logic             t_rdy;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_valid[i]             = t_v[i];
      in_opcode[i*3 +: 3]     = t_op[i];
      in_size[i*SW +: SW]     = t_sz[i];
      in_source[i*SRCW +: SRCW] = t_src[i];
      in_denied[i]            = t_den[i];
      in_corrupt[i]           = t_cor[i];
      in_user[i*UW +: UW]     = t_usr[i];
      in_data[i*DW +: DW]     = t_dat[i];
    end
    out_ready = t_rdy;
  end

  dcache_tl_d_arbiter #(
    .NUM_IN(N), .DATA_W(DW), .SIZE_W(SW), .SOURCE_W(SRCW), .USER_W(UW), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_size(in_size), .in_source(in_source), .in_denied(in_denied),
    .in_corrupt(in_corrupt), .in_user(in_user), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_size(out_size), .out_source(out_source), .out_denied(out_denied),
    .out_corrupt(out_corrupt), .out_user(out_user), .out_data(out_data),
    .out_sel(out_sel), .proto_err(proto_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Message-level reference: which source owns the channel and how many beats it still owes.
  bit         m_burst;
  int         m_lock, m_left, m_ptr;
  logic [2:0] m_op;
  logic [SW-1:0] m_sz;
  bit         m_err;
  int         e_sel;
  bit         e_valid, e_fire;
  logic [N-1:0] e_rdy;

  function automatic int msg_beats(input logic [2:0] op, input int sz);
    if (((op == 3'd1) || (op == 3'd5)) && (sz > BEAT_LG)) return 1 << (sz - BEAT_LG);
    return 1;
  endfunction

  task automatic model_reset();
    m_burst = 0; m_lock = 0; m_left = 0; m_ptr = 0; m_op = 0; m_sz = 0; m_err = 0;
  endtask

  task automatic model_eval();
    e_rdy = '0; e_valid = 0; e_sel = 0;
    if (m_burst) begin
      e_sel = m_lock; e_valid = t_v[m_lock]; e_rdy[m_lock] = t_rdy;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!e_valid && t_v[(m_ptr + k) % N]) begin
          e_sel = (m_ptr + k) % N; e_valid = 1;
        end
      end
      if (e_valid) e_rdy[e_sel] = t_rdy;
    end
    e_fire = e_valid && t_rdy;
  endtask

  task automatic model_step();
    int b;
    if (!e_fire) return;
    if (!m_burst) begin
      b = msg_beats(t_op[e_sel], int'(t_sz[e_sel]));
      if (b == 1) m_ptr = (e_sel + 1) % N;
      else begin
        m_burst = 1; m_lock = e_sel; m_left = b - 1; m_op = t_op[e_sel]; m_sz = t_sz[e_sel];
      end
    end else begin
      if ((t_op[m_lock] != m_op) || (t_sz[m_lock] != m_sz)) m_err = 1;
      m_left--;
      if (m_left == 0) begin
        m_burst = 0; m_ptr = (m_lock + 1) % N;
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_eval();
    chk("out_valid", out_valid, e_valid);
    chk("in_ready", in_ready, e_rdy);
    if (e_valid) begin
      chk("out_sel", out_sel, e_sel);
      chk("out_fields",
          {out_opcode, out_size, out_source, out_denied, out_corrupt, out_user, out_data},
          {t_op[e_sel], t_sz[e_sel], t_src[e_sel], t_den[e_sel], t_cor[e_sel],
           t_usr[e_sel], t_dat[e_sel]});
    end
    chk("proto_err", proto_err, m_err);
  endtask

  task automatic advance();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_src(input int i, input bit v, input logic [2:0] op,
                         input logic [SW-1:0] sz, input logic [DW-1:0] d);
    t_v[i] = v; t_op[i] = op; t_sz[i] = sz; t_dat[i] = d;
    t_src[i] = SRCW'(i); t_usr[i] = UW'(i + 5); t_den[i] = (i == 1); t_cor[i] = (i == 2);
  endtask

  task automatic clear_valids();
    for (int i = 0; i < N; i++) t_v[i] = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) t_v[i] = 1;
    t_rdy = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clock); #2;
    chk("rst_proto_err", proto_err, 0);
    chk("rst_out_valid_hold", out_valid, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    clear_valids();
  endtask

  typedef struct {
    logic [N-1:0] v;
    bit           rdy;
    int           sel;
    bit           val;
    logic [N-1:0] rd;
  } vec_t;

  vec_t tbl[10];
  int   s_left[N];
  bit   fired[N];
  logic [2:0] ops[6];
  logic [DW-1:0] held;

  initial begin
    tbl[0] = '{3'b011, 1'b1, 0, 1'b1, 3'b001};
    tbl[1] = '{3'b011, 1'b1, 1, 1'b1, 3'b010};
    tbl[2] = '{3'b011, 1'b1, 0, 1'b1, 3'b001};
    tbl[3] = '{3'b100, 1'b0, 2, 1'b1, 3'b000};
    tbl[4] = '{3'b100, 1'b1, 2, 1'b1, 3'b100};
    tbl[5] = '{3'b000, 1'b1, 0, 1'b0, 3'b000};
    tbl[6] = '{3'b110, 1'b1, 1, 1'b1, 3'b010};
    tbl[7] = '{3'b111, 1'b1, 2, 1'b1, 3'b100};
    tbl[8] = '{3'b101, 1'b1, 0, 1'b1, 3'b001};
    tbl[9] = '{3'b101, 1'b1, 2, 1'b1, 3'b100};
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

    for (int i = 0; i < N; i++) begin
      set_src(i, 0, 3'd0, 3'd2, DW'(32'h100 + i));
      s_left[i] = 0;
    end
    t_rdy = 1'b0;
    model_reset();
    do_reset();

    // Single-beat arbitration vectors from reset (rr_ptr starts at 0).
    for (int i = 0; i < N; i++) set_src(i, 0, 3'd0, 3'd2, DW'(32'h100 + i));
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) t_v[i] = tbl[r].v[i];
      t_rdy = tbl[r].rdy;
      sample();
      chk("tbl_valid", out_valid, tbl[r].val);
      if (tbl[r].val) chk("tbl_sel", out_sel, tbl[r].sel);
      chk("tbl_ready", in_ready, tbl[r].rd);
      advance();
    end
    clear_valids();

    // 4-beat GrantData from src1 while src0 waits.
    do_reset();
    t_rdy = 1;
    set_src(0, 1, 3'd0, 3'd2, 32'hA0);
    sample(); advance();
    set_src(0, 1, 3'd0, 3'd2, 32'hA1);
    set_src(1, 1, 3'd5, 3'd4, 32'hB0);
    for (int b = 0; b < 4; b++) begin
      sample();
      chk("burstA_sel", out_sel, 1);
      chk("burstA_rdy0", in_ready[0], 0);
      advance();
      t_dat[1] = t_dat[1] + 1;
    end
    sample();
    chk("burstA_next_sel", out_sel, 0);
    advance();
    clear_valids();

    // Backpressure mid-burst.
    do_reset();
    t_rdy = 1;
    set_src(0, 1, 3'd1, 3'd4, 32'hC0);
    for (int b = 0; b < 2; b++) begin
      sample(); advance(); t_dat[0] = t_dat[0] + 1;
    end
    held = t_dat[0];
    t_rdy = 0;
    set_src(1, 1, 3'd0, 3'd2, 32'hD0);
    for (int s = 0; s < 3; s++) begin
      sample();
      chk("stall_data", out_data, held);
      chk("stall_valid", out_valid, 1);
      advance();
    end
    t_rdy = 1;
    for (int b = 0; b < 2; b++) begin
      sample(); advance(); t_dat[0] = t_dat[0] + 1;
    end
    set_src(0, 1, 3'd0, 3'd2, 32'hC9);
    sample();
    chk("post_stall_sel", out_sel, 1);
    advance();
    clear_valids();

    // Locked source drops valid between beats.
    do_reset();
    t_rdy = 1;
    set_src(0, 1, 3'd5, 3'd4, 32'hE0);
    set_src(1, 1, 3'd0, 3'd2, 32'hF0);
    sample(); advance(); t_dat[0] = t_dat[0] + 1;
    t_v[0] = 0;
    for (int s = 0; s < 2; s++) begin
      sample();
      chk("drop_valid", out_valid, 0);
      chk("drop_rdy1", in_ready[1], 0);
      advance();
    end
    t_v[0] = 1;
    for (int b = 0; b < 3; b++) begin
      sample();
      chk("drop_sel", out_sel, 0);
      advance();
      t_dat[0] = t_dat[0] + 1;
    end
    t_v[0] = 0;
    sample();
    chk("drop_after_sel", out_sel, 1);
    advance();
    clear_valids();

    // Opcode changes on the second beat: sticky protocol error.
    do_reset();
    t_rdy = 1;
    set_src(0, 1, 3'd5, 3'd3, 32'h10);
    sample(); advance();
    t_op[0] = 3'd1; t_dat[0] = 32'h11;
    sample(); advance();
    t_v[0] = 0;
    for (int s = 0; s < 3; s++) begin
      sample();
      chk("proto_err_sticky", proto_err, 1);
      advance();
    end

    // Reset asserted during beat 2 of an 8-beat burst.
    set_src(0, 1, 3'd0, 3'd2, 32'h20);
    sample(); advance();
    set_src(0, 1, 3'd0, 3'd2, 32'h21);
    set_src(1, 1, 3'd5, 3'd5, 32'h30);
    sample(); advance();
    t_dat[1] = 32'h31;
    sample();
    do_reset();
    t_rdy = 1;
    set_src(0, 1, 3'd0, 3'd2, 32'h22);
    set_src(1, 1, 3'd0, 3'd2, 32'h32);
    sample();
    chk("post_reset_sel", out_sel, 0);
    chk("post_reset_err", proto_err, 0);
    advance();
    clear_valids();

    // Random traffic with per-source well-formed messages.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!t_v[i]) begin
          if (s_left[i] == 0) begin
            set_src(i, 0, ops[$urandom_range(5, 0)], SW'($urandom_range(5, 0)), $urandom);
            t_src[i] = SRCW'($urandom); t_usr[i] = UW'($urandom);
            t_den[i] = 1'($urandom); t_cor[i] = 1'($urandom);
            s_left[i] = msg_beats(t_op[i], int'(t_sz[i]));
          end
          t_v[i] = ($urandom_range(2, 0) != 0);
        end
      end
      t_rdy = ($urandom_range(3, 0) != 0);
      sample();
      for (int i = 0; i < N; i++) fired[i] = t_v[i] && e_rdy[i];
      advance();
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          s_left[i]--;
          t_dat[i] = $urandom;
          t_v[i] = (s_left[i] != 0) && ($urandom_range(1, 0) != 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
